rf_writeback: RTL and testbench
===============================

RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL take parameter RW, default `RW (16), meaning register data width.
REQ-002 SHALL take parameter REGNO, default `REGNO (8), meaning number of registers.
REQ-003 SHALL take parameter REGNO_LOG, default `REGNO_LOG (3), meaning register index width.
REQ-004 SHALL have port i_clk  in  1  sole clock, all state on posedge.
REQ-005 SHALL have port i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_ex_valid  in  1  execute result offered.
REQ-007 SHALL have port o_ex_ready  out  1  execute result accepted this cycle when high with i_ex_valid.
REQ-008 SHALL have ports i_ex_reg  in  REGNO_LOG, i_ex_data  in  RW, i_ex_data_hi  in  RW, i_ex_pair  in  1: destination, low word, high word, 32-bit pair write flag.
REQ-009 SHALL have ports i_mem_valid  in  1, o_mem_ready  out  1, i_mem_reg  in  REGNO_LOG, i_mem_data  in  RW: single-word load result channel.
REQ-010 SHALL have ports o_rf_ie  out  REGNO (one-hot write enable), o_rf_gie  out  1 (global write enable), o_rf_d  out  RW (write data), feeding the register file directly.
REQ-011 SHALL have port o_busy_mask  out  REGNO: bit i high while any queued write targets register i.

Function
REQ-012 SHALL hold pending writes in a 2-entry FIFO; entry = {reg, data_lo, data_hi, pair}; count 0..2.
REQ-013 SHALL accept at most one entry per cycle; memory channel has priority.
REQ-014 o_mem_ready SHALL equal (count < 2); o_ex_ready SHALL equal (count < 2) AND NOT i_mem_valid.
REQ-015 SHALL NOT accept when count = 2, even if the head pops the same cycle (no full-pass-through).
REQ-016 Drain FSM states: IDLE (count = 0), WR_LO, WR_HI.
REQ-017 IDLE -> WR_LO when count becomes nonzero; WR_LO on non-pair head: write head.reg with data_lo, pop, stay WR_LO if count after pop > 0 else IDLE.
REQ-018 WR_LO on pair head: write register (reg & ~1) with data_lo, go WR_HI; WR_HI: write register (reg | 1) with data_hi, pop, next WR_LO or IDLE per remaining count.
REQ-019 Write outputs SHALL be registered: o_rf_gie=1, o_rf_ie=one-hot(target), o_rf_d=data during exactly one cycle per word written; otherwise o_rf_gie=0, o_rf_ie=0, o_rf_d=0.
REQ-020 Latency: entry accepted at edge k into empty FIFO SHALL appear on write outputs in cycle after edge k+1; register file captures at edge k+2.
REQ-021 Simultaneous accept and pop SHALL leave count unchanged; FIFO pointers wrap modulo 2.
REQ-022 o_busy_mask SHALL be combinational OR over valid entries (pair entry sets both reg&~1 and reg|1), cleared for an entry the cycle after its final word is presented.
REQ-023 Ordering SHALL be preserved: writes reach the register file in acceptance order.
REQ-024 Pair flag on memory channel SHALL NOT exist; memory entries always single-word.

Reset
REQ-025 While i_rst_n=0 at posedge: count=0, pointers=0, FSM=IDLE, o_rf_gie=0, o_rf_ie=0, o_rf_d=0; ready outputs SHALL read 0 while i_rst_n low.
REQ-026 Reset mid-pair (in WR_HI) SHALL drop the high-word write; no partial write after reset release.
REQ-027 First accept permitted on the first posedge with i_rst_n=1.

Structure
REQ-028 RW, REGNO, REGNO_LOG SHALL come from the shared config include; FSM state encodings SHALL be localparams in this module (not shared).
REQ-029 FIFO storage SHALL be one sub-module, wb_fifo (2-deep, push/pop/count/full/empty, entry-valid vector for busy mask).

Verification
REQ-030 Reset then mem write reg3=0xBEEF -> two cycles later o_rf_ie=8'b00001000, o_rf_d=0xBEEF, o_rf_gie=1 for one cycle.
REQ-031 ex pair reg5, lo=0x1234, hi=0xABCD -> consecutive cycles: ie=bit4 d=0x1234, then ie=bit5 d=0xABCD; busy_mask bits 4,5 set until done.
REQ-032 mem and ex valid same cycle -> o_ex_ready=0, mem accepted first, ex accepted next cycle, writes in that order.
REQ-033 Three back-to-back single writes with pair at head -> o_mem_ready/o_ex_ready drop at count 2, no entry lost, order preserved.
REQ-034 i_rst_n low during WR_HI of pair reg1 -> no write to reg1 after reset, outputs 0, busy_mask 0.
REQ-035 Accept while popping at count 1 continuously for 10 cycles -> one write per cycle, count stays 1, ready never drops.

Source files
------------

// File: rtl/rf_writeback_pkg.sv
// rf_writeback_pkg -- shared configuration for the register-file writeback slice.
//   CFG_RW        : register data width
//   CFG_REGNO     : number of architectural registers
//   CFG_REGNO_LOG : register index width
package rf_writeback_pkg;

  localparam int unsigned CFG_RW        = 16;
  localparam int unsigned CFG_REGNO     = 8;
  localparam int unsigned CFG_REGNO_LOG = 3;

endpackage

// File: rtl/rf_writeback_fifo.sv
// wb_fifo -- 2-deep queue of pending register-file writes.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   push, push_*   : enqueue one entry {reg, lo, hi, pair}; ignored when full
//   pop            : dequeue head entry; ignored when empty
//   head_*         : fields of the oldest entry
//   count/full/empty : occupancy
//   ent_vld/ent_reg/ent_pair : per-slot view used to build the busy mask
module wb_fifo
  import rf_writeback_pkg::*;
#(
  parameter int unsigned RW        = CFG_RW,
  parameter int unsigned REGNO_LOG = CFG_REGNO_LOG
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 push,
  input  logic [REGNO_LOG-1:0] push_reg,
  input  logic [RW-1:0]        push_lo,
  input  logic [RW-1:0]        push_hi,
  input  logic                 push_pair,
  input  logic                 pop,
  output logic [REGNO_LOG-1:0] head_reg,
  output logic [RW-1:0]        head_lo,
  output logic [RW-1:0]        head_hi,
  output logic                 head_pair,
  output logic [1:0]           count,
  output logic                 full,
  output logic                 empty,
  output logic [1:0]           ent_vld,
  output logic [REGNO_LOG-1:0] ent_reg [2],
  output logic [1:0]           ent_pair
);

  logic [REGNO_LOG-1:0] reg_q [2];
  logic [RW-1:0]        lo_q  [2];
  logic [RW-1:0]        hi_q  [2];
  logic [1:0]           pair_q;
  logic [1:0]           vld_q;
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = &vld_q;
  assign empty   = ~|vld_q;
  assign count   = {1'b0, vld_q[0]} + {1'b0, vld_q[1]};
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // With the guards above, push and pop can only hit the same slot when
  // one of them is suppressed, so the two vld_q updates never collide.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_ok) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_ok) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      reg_q[wr_ptr]  <= push_reg;
      lo_q[wr_ptr]   <= push_lo;
      hi_q[wr_ptr]   <= push_hi;
      pair_q[wr_ptr] <= push_pair;
    end
  end

  assign head_reg  = reg_q[rd_ptr];
  assign head_lo   = lo_q[rd_ptr];
  assign head_hi   = hi_q[rd_ptr];
  assign head_pair = pair_q[rd_ptr];

  assign ent_vld    = vld_q;
  assign ent_reg[0] = reg_q[0];
  assign ent_reg[1] = reg_q[1];
  assign ent_pair   = pair_q;

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback -- merges execute and load results into a 2-entry write queue
// and drains it into the register file one word per cycle.
//   i_clk, i_rst_n       : clock, synchronous active-low reset
//   i_ex_*  / o_ex_ready : execute results (optionally a 32-bit register pair)
//   i_mem_* / o_mem_ready: load results (single word, priority over execute)
//   o_rf_ie/o_rf_gie/o_rf_d : registered one-hot write port to the register file
//   o_busy_mask          : registers targeted by any still-queued write
module rf_writeback
  import rf_writeback_pkg::*;
#(
  parameter int unsigned RW        = CFG_RW,
  parameter int unsigned REGNO     = CFG_REGNO,
  parameter int unsigned REGNO_LOG = CFG_REGNO_LOG
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_ex_valid,
  output logic                 o_ex_ready,
  input  logic [REGNO_LOG-1:0] i_ex_reg,
  input  logic [RW-1:0]        i_ex_data,
  input  logic [RW-1:0]        i_ex_data_hi,
  input  logic                 i_ex_pair,
  input  logic                 i_mem_valid,
  output logic                 o_mem_ready,
  input  logic [REGNO_LOG-1:0] i_mem_reg,
  input  logic [RW-1:0]        i_mem_data,
  output logic [REGNO-1:0]     o_rf_ie,
  output logic                 o_rf_gie,
  output logic [RW-1:0]        o_rf_d,
  output logic [REGNO-1:0]     o_busy_mask
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WR_LO = 2'd1;
  localparam logic [1:0] ST_WR_HI = 2'd2;

  localparam logic [REGNO_LOG-1:0] LSB = REGNO_LOG'(1);

  logic [1:0]           state_q;
  logic [1:0]           state_d;

  logic                 push;
  logic                 push_mem;
  logic [REGNO_LOG-1:0] push_reg;
  logic [RW-1:0]        push_lo;
  logic [RW-1:0]        push_hi;
  logic                 push_pair;
  logic                 pop;

  logic [REGNO_LOG-1:0] head_reg;
  logic [RW-1:0]        head_lo;
  logic [RW-1:0]        head_hi;
  logic                 head_pair;
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic                 full;
  logic                 empty;
  logic [1:0]           ent_vld;
  logic [REGNO_LOG-1:0] ent_reg [2];
  logic [1:0]           ent_pair;

  logic                 wr_en;
  logic [REGNO_LOG-1:0] wr_idx;
  logic [RW-1:0]        wr_data;

  // Acceptance is decided on the pre-edge occupancy only: a pop in the same
  // cycle never frees a slot for a push when the queue is full.
  assign o_mem_ready = i_rst_n & ~full;
  assign o_ex_ready  = i_rst_n & ~full & ~i_mem_valid;
  assign push_mem    = i_mem_valid & o_mem_ready;
  assign push        = push_mem | (i_ex_valid & o_ex_ready);
  assign push_reg    = push_mem ? i_mem_reg  : i_ex_reg;
  assign push_lo     = push_mem ? i_mem_data : i_ex_data;
  assign push_hi     = push_mem ? '0         : i_ex_data_hi;
  assign push_pair   = push_mem ? 1'b0       : i_ex_pair;

  wb_fifo #(
    .RW        (RW),
    .REGNO_LOG (REGNO_LOG)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (push),
    .push_reg  (push_reg),
    .push_lo   (push_lo),
    .push_hi   (push_hi),
    .push_pair (push_pair),
    .pop       (pop),
    .head_reg  (head_reg),
    .head_lo   (head_lo),
    .head_hi   (head_hi),
    .head_pair (head_pair),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ent_vld   (ent_vld),
    .ent_reg   (ent_reg),
    .ent_pair  (ent_pair)
  );

  // The word driven onto the write port at an edge is chosen from the
  // current head; the entry is popped on the same edge as its last word.
  always_comb begin
    pop     = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    state_d = ST_IDLE;
    if (state_q == ST_WR_HI) begin
      wr_en   = 1'b1;
      wr_idx  = head_reg | LSB;
      wr_data = head_hi;
      pop     = 1'b1;
    end else if (!empty) begin
      wr_en   = 1'b1;
      wr_data = head_lo;
      if (head_pair) begin
        wr_idx = head_reg & ~LSB;
      end else begin
        wr_idx = head_reg;
        pop    = 1'b1;
      end
    end
    count_next = count + 2'(push) - 2'(pop);
    if (wr_en && !pop) begin
      state_d = ST_WR_HI;
    end else if (count_next != 2'd0) begin
      state_d = ST_WR_LO;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      o_rf_gie <= 1'b0;
      o_rf_ie  <= '0;
      o_rf_d   <= '0;
    end else begin
      state_q  <= state_d;
      o_rf_gie <= wr_en;
      o_rf_ie  <= wr_en ? ({{(REGNO-1){1'b0}}, 1'b1} << wr_idx) : '0;
      o_rf_d   <= wr_data;
    end
  end

  always_comb begin
    o_busy_mask = '0;
    for (int unsigned e = 0; e < 2; e++) begin
      if (ent_vld[e]) begin
        if (ent_pair[e]) begin
          o_busy_mask[ent_reg[e] & ~LSB] = 1'b1;
          o_busy_mask[ent_reg[e] | LSB]  = 1'b1;
        end else begin
          o_busy_mask[ent_reg[e]] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

  localparam int unsigned RW        = 16;
  localparam int unsigned REGNO     = 8;
  localparam int unsigned REGNO_LOG = 3;

  logic                 clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_ex_valid;
  logic                 o_ex_ready;
  logic [REGNO_LOG-1:0] i_ex_reg;
  logic [RW-1:0]        i_ex_data;
  logic [RW-1:0]        i_ex_data_hi;
  logic                 i_ex_pair;
  logic                 i_mem_valid;
  logic                 o_mem_ready;
  logic [REGNO_LOG-1:0] i_mem_reg;
  logic [RW-1:0]        i_mem_data;
  logic [REGNO-1:0]     o_rf_ie;
  logic                 o_rf_gie;
  logic [RW-1:0]        o_rf_d;
  logic [REGNO-1:0]     o_busy_mask;

  always #5 clk = ~clk;

  rf_writeback #(
    .RW        (RW),
    .REGNO     (REGNO),
    .REGNO_LOG (REGNO_LOG)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_ex_valid   (i_ex_valid),
    .o_ex_ready   (o_ex_ready),
    .i_ex_reg     (i_ex_reg),
    .i_ex_data    (i_ex_data),
    .i_ex_data_hi (i_ex_data_hi),
    .i_ex_pair    (i_ex_pair),
    .i_mem_valid  (i_mem_valid),
    .o_mem_ready  (o_mem_ready),
    .i_mem_reg    (i_mem_reg),
    .i_mem_data   (i_mem_data),
    .o_rf_ie      (o_rf_ie),
    .o_rf_gie     (o_rf_gie),
    .o_rf_d       (o_rf_d),
    .o_busy_mask  (o_busy_mask)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of accepted entries, each with the number of
  // register words it still has to deliver.
  typedef struct {
    int unsigned r;
    logic [RW-1:0] lo;
    logic [RW-1:0] hi;
    bit pair;
    int unsigned left;
  } ment_t;

  ment_t            mq[$];
  logic             m_gie;
  logic [REGNO-1:0] m_ie;
  logic [RW-1:0]    m_d;
  logic [REGNO-1:0] m_busy;

  function automatic logic [REGNO-1:0] bit_of(input int unsigned idx);
    logic [REGNO-1:0] b;
    b = '0;
    b[idx] = 1'b1;
    return b;
  endfunction

  task automatic model_edge();
    ment_t e;
    bit room;
    int unsigned widx;
    int unsigned base;
    m_gie = 1'b0;
    m_ie  = '0;
    m_d   = '0;
    m_busy = '0;
    if (!i_rst_n) begin
      mq.delete();
      return;
    end
    room = (mq.size() < 2);
    if (mq.size() != 0) begin
      e = mq[0];
      base = e.r - (e.r % 2);
      m_gie = 1'b1;
      if (!e.pair) begin
        widx = e.r;
        m_d  = e.lo;
      end else if (e.left == 2) begin
        widx = base;
        m_d  = e.lo;
      end else begin
        widx = base + 1;
        m_d  = e.hi;
      end
      m_ie = bit_of(widx);
      if (e.left == 1) void'(mq.pop_front());
      else mq[0].left = 1;
    end
    if (room && (i_mem_valid || i_ex_valid)) begin
      if (i_mem_valid) begin
        e.r = i_mem_reg; e.lo = i_mem_data; e.hi = '0; e.pair = 1'b0; e.left = 1;
      end else begin
        e.r = i_ex_reg; e.lo = i_ex_data; e.hi = i_ex_data_hi; e.pair = i_ex_pair;
        e.left = i_ex_pair ? 2 : 1;
      end
      mq.push_back(e);
    end
    foreach (mq[k]) begin
      base = mq[k].r - (mq[k].r % 2);
      if (mq[k].pair) m_busy = m_busy | bit_of(base) | bit_of(base + 1);
      else m_busy = m_busy | bit_of(mq[k].r);
    end
  endtask

  typedef struct {
    bit rst; bit mv; logic [REGNO_LOG-1:0] mr; logic [RW-1:0] md;
    bit ev; logic [REGNO_LOG-1:0] er; logic [RW-1:0] elo; logic [RW-1:0] ehi; bit ep;
    bit xmr; bit xer; bit xg; logic [REGNO-1:0] xie; logic [RW-1:0] xd; logic [REGNO-1:0] xb;
  } vec_t;

  function automatic vec_t mk(input int unsigned rst, mv, mr, md, ev, er, elo, ehi, ep,
                              xmr, xer, xg, xie, xd, xb);
    vec_t v;
    v.rst = (rst != 0); v.mv = (mv != 0); v.mr = REGNO_LOG'(mr); v.md = RW'(md);
    v.ev = (ev != 0); v.er = REGNO_LOG'(er); v.elo = RW'(elo); v.ehi = RW'(ehi);
    v.ep = (ep != 0); v.xmr = (xmr != 0); v.xer = (xer != 0); v.xg = (xg != 0);
    v.xie = REGNO'(xie); v.xd = RW'(xd); v.xb = REGNO'(xb);
    return v;
  endfunction

  function automatic vec_t idle(input int unsigned xg, xie, xd, xb);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, xg, xie, xd, xb);
  endfunction

  // Drive inputs after the falling edge and check the ready outputs.
  task automatic apply(input vec_t v);
    @(negedge clk);
    i_rst_n      = v.rst;
    i_mem_valid  = v.mv;
    i_mem_reg    = v.mr;
    i_mem_data   = v.md;
    i_ex_valid   = v.ev;
    i_ex_reg     = v.er;
    i_ex_data    = v.elo;
    i_ex_data_hi = v.ehi;
    i_ex_pair    = v.ep;
    #1;
    chk("mem_ready", o_mem_ready, i_rst_n && (mq.size() < 2));
    chk("ex_ready", o_ex_ready, i_rst_n && (mq.size() < 2) && !i_mem_valid);
  endtask

  // Advance one clock, step the model and compare the registered outputs.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("rf_gie", o_rf_gie, m_gie);
    chk("rf_ie", o_rf_ie, m_ie);
    chk("rf_d", o_rf_d, m_d);
    chk("busy_mask", o_busy_mask, m_busy);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;

    i_rst_n = 1'b0; i_mem_valid = 1'b0; i_mem_reg = '0; i_mem_data = '0;
    i_ex_valid = 1'b0; i_ex_reg = '0; i_ex_data = '0; i_ex_data_hi = '0; i_ex_pair = 1'b0;

    //              rst mv mr md      ev er elo     ehi     ep xmr xer xg xie   xd      xb
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0,      0, 0,  0,  0, 0,    0,      0));
    tbl.push_back(mk(1, 1, 3, 'hBEEF, 0, 0, 0,      0,      0, 1,  0,  0, 0,    0,      'h08));
    tbl.push_back(idle(1, 'h08, 'hBEEF, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,      1, 5, 'h1234, 'hABCD, 1, 1,  1,  0, 0,    0,      'h30));
    tbl.push_back(idle(1, 'h10, 'h1234, 'h30));
    tbl.push_back(idle(1, 'h20, 'hABCD, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 'h1111, 1, 6, 'h2222, 0,      0, 1,  0,  0, 0,    0,      'h04));
    tbl.push_back(mk(1, 0, 0, 0,      1, 6, 'h2222, 0,      0, 1,  1,  1, 'h04, 'h1111, 'h40));
    tbl.push_back(idle(1, 'h40, 'h2222, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,      1, 1, 'hA0A0, 'hB0B0, 1, 1,  1,  0, 0,    0,      'h03));
    tbl.push_back(mk(1, 1, 7, 'h7777, 0, 0, 0,      0,      0, 1,  0,  1, 'h01, 'hA0A0, 'h83));
    tbl.push_back(mk(1, 1, 4, 'h4444, 0, 0, 0,      0,      0, 0,  0,  1, 'h02, 'hB0B0, 'h80));
    tbl.push_back(mk(1, 1, 4, 'h4444, 0, 0, 0,      0,      0, 1,  0,  1, 'h80, 'h7777, 'h10));
    tbl.push_back(mk(1, 0, 0, 0,      1, 6, 'h6666, 0,      0, 1,  1,  1, 'h10, 'h4444, 'h40));
    tbl.push_back(idle(1, 'h40, 'h6666, 0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,      1, 1, 'h0101, 'h0202, 1, 1,  1,  0, 0,    0,      'h03));
    tbl.push_back(idle(1, 'h01, 'h0101, 'h03));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0, 0,      0,      0, 0,  0,  0, 0,    0,      0));
    tbl.push_back(idle(0, 0, 0, 0));
    tbl.push_back(idle(0, 0, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i]);
      chk($sformatf("t%0d_mem_ready", i), o_mem_ready, tbl[i].xmr);
      chk($sformatf("t%0d_ex_ready", i), o_ex_ready, tbl[i].xer);
      tick();
      chk($sformatf("t%0d_gie", i), o_rf_gie, tbl[i].xg);
      chk($sformatf("t%0d_ie", i), o_rf_ie, tbl[i].xie);
      chk($sformatf("t%0d_d", i), o_rf_d, tbl[i].xd);
      chk($sformatf("t%0d_busy", i), o_busy_mask, tbl[i].xb);
    end

    // Steady stream at occupancy 1: one write per cycle, ready never drops.
    apply(mk(1, 1, 0, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(mk(1, 1, (i + 1) % 8, 'h101 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("stream_mem_ready", o_mem_ready, 1);
      tick();
      chk("stream_gie", o_rf_gie, 1);
      chk("stream_d", o_rf_d, 'h100 + i);
    end
    apply(idle(0, 0, 0, 0));
    tick();
    chk("stream_d_last", o_rf_d, 'h10A);
    apply(idle(0, 0, 0, 0));
    tick();

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      v = mk(($urandom_range(0, 99) < 3) ? 0 : 1,
             ($urandom_range(0, 99) < 40) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 'hFFFF),
             ($urandom_range(0, 99) < 60) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 'hFFFF),
             $urandom_range(0, 'hFFFF), $urandom_range(0, 1), 0, 0, 0, 0, 0, 0);
      apply(v);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
